// File: rtl/axil_slave_responder_pkg.sv
// Response codes and FSM state encodings shared by the AXI-Lite register responder.
package pkg_axil_resp;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;

    typedef logic [1:0] wr_state_t;
    localparam wr_state_t W_IDLE  = 2'd0;
    localparam wr_state_t W_DELAY = 2'd1;
    localparam wr_state_t W_RESP  = 2'd2;

    typedef logic [1:0] rd_state_t;
    localparam rd_state_t R_IDLE  = 2'd0;
    localparam rd_state_t R_DELAY = 2'd1;
    localparam rd_state_t R_RESP  = 2'd2;

endpackage

// File: rtl/axil_slave_responder_lfsr.sv
// Free-running 16-bit LFSR (x^16+x^14+x^13+x^11) that turns its state into two
// response delays in [DELAY_MIN, DELAY_MAX], one for the write path and one for the read path.
module axil_delay_lfsr #(
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int          DELAY_MIN = 2,
    parameter int          DELAY_MAX = 17,
    parameter int          DLY_W     = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             step_i,
    output logic [DLY_W-1:0] delay_a_o,
    output logic [DLY_W-1:0] delay_b_o
);

    localparam int SPAN = DELAY_MAX - DELAY_MIN + 1;

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    logic        feedback;

    always_comb begin
        feedback = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
        lfsr_d   = step_i ? {lfsr_q[14:0], feedback} : lfsr_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // The read path uses the byte-swapped state so both channels draw distinct samples.
    assign delay_a_o = DLY_W'(DELAY_MIN + (int'(lfsr_q) % SPAN));
    assign delay_b_o = DLY_W'(DELAY_MIN + (int'({lfsr_q[7:0], lfsr_q[15:8]}) % SPAN));

endmodule

// File: rtl/axil_slave_responder.sv
// AXI-Lite slave serving a word-addressed register bank in one address window.
// Define AXIL_RESP_DELAY_EN to add an LFSR-driven random delay before each response.
module axil_slave_responder
    import pkg_axil_resp::*;
#(
    parameter int                        AXI_DATA_WIDTH  = 32,
    parameter int                        AXI_ADDR_WIDTH  = 32,
    parameter logic [AXI_ADDR_WIDTH-1:0] AXI_ADDR_OFFSET = '0,
    parameter logic [AXI_ADDR_WIDTH-1:0] AXI_ADDR_RANGE  = AXI_ADDR_WIDTH'(32'h0000_FFFF),
    parameter int                        REG_NUM         = 16,
    parameter int                        DELAY_MIN       = 2,
    parameter int                        DELAY_MAX       = 17,
    parameter logic [15:0]               LFSR_SEED       = 16'hACE1
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic [AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
    input  logic                          s_axi_awvalid,
    output logic                          s_axi_awready,
    input  logic [AXI_DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
    input  logic                          s_axi_wvalid,
    output logic                          s_axi_wready,
    output logic [1:0]                    s_axi_bresp,
    output logic                          s_axi_bvalid,
    input  logic                          s_axi_bready,
    input  logic [AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
    input  logic                          s_axi_arvalid,
    output logic                          s_axi_arready,
    output logic [AXI_DATA_WIDTH-1:0]     s_axi_rdata,
    output logic [1:0]                    s_axi_rresp,
    output logic                          s_axi_rvalid,
    input  logic                          s_axi_rready
);

    localparam int BYTES    = AXI_DATA_WIDTH / 8;
    localparam int OFF_BITS = $clog2(BYTES);
    localparam int IDX_W    = (REG_NUM < 2) ? 1 : $clog2(REG_NUM);
    localparam int DLY_W    = (DELAY_MAX < 2) ? 1 : $clog2(DELAY_MAX + 1);

    if (DELAY_MAX < DELAY_MIN || LFSR_SEED == 16'h0 || AXI_DATA_WIDTH % 8 != 0) begin : g_bad_cfg
        $error("axil_slave_responder: invalid DELAY_MIN/DELAY_MAX/LFSR_SEED/AXI_DATA_WIDTH");
    end

    logic [AXI_DATA_WIDTH-1:0] regs_q [REG_NUM];

    wr_state_t                 wrState_q, wrState_d;
    logic                      awready_q, awready_d, wready_q, wready_d;
    logic [AXI_ADDR_WIDTH-1:0] awAddr_q, awAddr_d;
    logic [AXI_DATA_WIDTH-1:0] wData_q, wData_d;
    logic [BYTES-1:0]          wStrb_q, wStrb_d;
    logic [DLY_W-1:0]          wrCnt_q, wrCnt_d;
    logic                      bvalid_q, bvalid_d;
    resp_t                     bresp_q, bresp_d;

    rd_state_t                 rdState_q, rdState_d;
    logic                      arready_q, arready_d;
    logic [DLY_W-1:0]          rdCnt_q, rdCnt_d;
    logic                      rvalid_q, rvalid_d;
    resp_t                     rresp_q, rresp_d;
    logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic                      awFire, wFire, wrCommit;
    logic [AXI_ADDR_WIDTH-1:0] wrAddr, wrWord, rdWord;
    logic [AXI_DATA_WIDTH-1:0] wrData;
    logic [BYTES-1:0]          wrStrb;
    resp_t                     wrResp, rdResp;
    logic [DLY_W-1:0]          wrDelay, rdDelay;

`ifdef AXIL_RESP_DELAY_EN
    axil_delay_lfsr #(
        .SEED      (LFSR_SEED),
        .DELAY_MIN (DELAY_MIN),
        .DELAY_MAX (DELAY_MAX),
        .DLY_W     (DLY_W)
    ) u_delay (
        .clk_i     (aclk),
        .rst_i     (areset),
        .step_i    (1'b1),
        .delay_a_o (wrDelay),
        .delay_b_o (rdDelay)
    );
`else
    assign wrDelay = '0;
    assign rdDelay = '0;
`endif

    // Window check first, then whether the word index lands on an implemented register.
    function automatic resp_t decodeAddr(input logic [AXI_ADDR_WIDTH-1:0] addr,
                                         input logic [AXI_ADDR_WIDTH-1:0] word);
        if (addr < AXI_ADDR_OFFSET || (addr - AXI_ADDR_OFFSET) > AXI_ADDR_RANGE) begin
            return RESP_DECERR;
        end
        if (word >= AXI_ADDR_WIDTH'(REG_NUM)) begin
            return RESP_SLVERR;
        end
        return RESP_OKAY;
    endfunction

    assign awFire = s_axi_awvalid && awready_q;
    assign wFire  = s_axi_wvalid && wready_q;
    assign wrAddr = awFire ? s_axi_awaddr : awAddr_q;
    assign wrData = wFire ? s_axi_wdata : wData_q;
    assign wrStrb = wFire ? s_axi_wstrb : wStrb_q;
    assign wrWord = (wrAddr - AXI_ADDR_OFFSET) >> OFF_BITS;
    assign wrResp = decodeAddr(wrAddr, wrWord);
    assign rdWord = (s_axi_araddr - AXI_ADDR_OFFSET) >> OFF_BITS;
    assign rdResp = decodeAddr(s_axi_araddr, rdWord);

    always_comb begin
        wrState_d = wrState_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        awAddr_d  = awAddr_q;
        wData_d   = wData_q;
        wStrb_d   = wStrb_q;
        wrCnt_d   = wrCnt_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        wrCommit  = 1'b0;
        case (wrState_q)
            W_IDLE: begin
                if (awFire) begin
                    awready_d = 1'b0;
                    awAddr_d  = s_axi_awaddr;
                end
                if (wFire) begin
                    wready_d = 1'b0;
                    wData_d  = s_axi_wdata;
                    wStrb_d  = s_axi_wstrb;
                end
                if ((awFire || !awready_q) && (wFire || !wready_q)) begin
                    wrCommit  = 1'b1;
                    bresp_d   = wrResp;
                    wrCnt_d   = wrDelay;
                    wrState_d = W_DELAY;
                end
            end
            W_DELAY: begin
                if (wrCnt_q == '0) begin
                    bvalid_d  = 1'b1;
                    wrState_d = W_RESP;
                end else begin
                    wrCnt_d = wrCnt_q - 1'b1;
                end
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                    wrState_d = W_IDLE;
                end
            end
            default: wrState_d = W_IDLE;
        endcase
    end

    // Read data is sampled from the bank before any same-edge write lands.
    always_comb begin
        rdState_d = rdState_q;
        arready_d = arready_q;
        rdCnt_d   = rdCnt_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        case (rdState_q)
            R_IDLE: begin
                if (s_axi_arvalid && arready_q) begin
                    arready_d = 1'b0;
                    rresp_d   = rdResp;
                    rdata_d   = (rdResp == RESP_OKAY) ? regs_q[rdWord[IDX_W-1:0]] : '0;
                    rdCnt_d   = rdDelay;
                    rdState_d = R_DELAY;
                end
            end
            R_DELAY: begin
                if (rdCnt_q == '0) begin
                    rvalid_d  = 1'b1;
                    rdState_d = R_RESP;
                end else begin
                    rdCnt_d = rdCnt_q - 1'b1;
                end
            end
            R_RESP: begin
                if (s_axi_rready) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    rdState_d = R_IDLE;
                end
            end
            default: rdState_d = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            wrState_q <= W_IDLE;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            awAddr_q  <= '0;
            wData_q   <= '0;
            wStrb_q   <= '0;
            wrCnt_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rdState_q <= R_IDLE;
            arready_q <= 1'b1;
            rdCnt_q   <= '0;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
        end else begin
            wrState_q <= wrState_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            awAddr_q  <= awAddr_d;
            wData_q   <= wData_d;
            wStrb_q   <= wStrb_d;
            wrCnt_q   <= wrCnt_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rdState_q <= rdState_d;
            arready_q <= arready_d;
            rdCnt_q   <= rdCnt_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wrCommit && wrResp == RESP_OKAY) begin
            for (int b = 0; b < BYTES; b++) begin
                if (wrStrb[b]) begin
                    regs_q[wrWord[IDX_W-1:0]][b*8 +: 8] <= wrData[b*8 +: 8];
                end
            end
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rdata   = rdata_q;

endmodule
